register_sequencer: RTL and testbench

Initiator-side controller for the 8×8-bit three-port register file: accepts one register-to-register instruction per handshake, drives the read selects, captures both operands, computes an 8-bit result and drives the write port. It sits between the instruction source and the register file, and owns every `asel`/`bsel`/`csel`/`cload`/`cin` signal in the datapath.

---
 rtl/regseq_pkg.sv | 23 ++
 rtl/register_sequencer_if.sv | 34 +++
 rtl/regseq_alu.sv | 54 +++++
 rtl/register_sequencer.sv | 145 ++++++++++++++
 tb/tb_register_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regseq_pkg.sv
// Shared constants and types for the register_sequencer block.
package regseq_pkg;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/register_sequencer_if.sv
// Instruction handshake plus the three-port register file connection.
// Handshake: an instruction transfers on a rising edge where ins_valid and
// ins_ready are both 1; ins_valid seen while ins_ready is 0 is ignored and
// need not be held.
interface register_sequencer_if;
  import regseq_pkg::*;

  logic              ins_valid;
  logic              ins_ready;
  logic [2:0]        ins_op;
  logic [IDX_W-1:0]  ins_dst;
  logic [IDX_W-1:0]  ins_srca;
  logic [IDX_W-1:0]  ins_srcb;
  logic [DATA_W-1:0] ins_imm;

  logic [IDX_W-1:0]  asel;
  logic [IDX_W-1:0]  bsel;
  logic [DATA_W-1:0] aout;
  logic [DATA_W-1:0] bout;
  logic [IDX_W-1:0]  csel;
  logic [DATA_W-1:0] cin;
  logic              cload;

  modport slave (
    input  ins_valid, ins_op, ins_dst, ins_srca, ins_srcb, ins_imm, aout, bout,
    output ins_ready, asel, bsel, csel, cin, cload
  );

  modport master (
    output ins_valid, ins_op, ins_dst, ins_srca, ins_srcb, ins_imm, aout, bout,
    input  ins_ready, asel, bsel, csel, cin, cload
  );

endinterface

// File: rtl/regseq_alu.sv
// Combinational 8-bit ALU; the carry output exists only with REGSEQ_FLAGS_EN.
module regseq_alu
  import regseq_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result
`ifdef REGSEQ_FLAGS_EN
  ,
  output logic              carry
`endif
);

  // The extra top bit is the carry (ADD) or borrow (SUB, set when a < b).
`ifdef REGSEQ_FLAGS_EN
  localparam int AW = DATA_W + 1;
`else
  localparam int AW = DATA_W;
`endif

  logic [AW-1:0] sum_w;
  logic [AW-1:0] diff_w;

  assign sum_w  = AW'(a) + AW'(b);
  assign diff_w = AW'(a) - AW'(b);

  always_comb begin
    result = '0;
    case (op)
      OP_MOV:  result = a;
      OP_ADD:  result = sum_w[DATA_W-1:0];
      OP_SUB:  result = diff_w[DATA_W-1:0];
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LDI:  result = imm;
      default: result = '0;
    endcase
  end

`ifdef REGSEQ_FLAGS_EN
  always_comb begin
    carry = 1'b0;
    case (op)
      OP_ADD:  carry = sum_w[AW-1];
      OP_SUB:  carry = diff_w[AW-1];
      default: carry = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/register_sequencer.sv
// Four-state sequencer driving the register file read/write ports.
// Optional zero/carry flags are built when REGSEQ_FLAGS_EN is defined.
module register_sequencer
  import regseq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  register_sequencer_if.slave   bus,
  output state_t                dbg_state,
  output logic                  done
`ifdef REGSEQ_FLAGS_EN
  ,
  output logic                  flag_z,
  output logic                  flag_c
`endif
);

  state_t state_q, state_d;
  logic   idle_phase;
  logic   write_phase;
  logic   accept;

  logic [2:0]        op_q;
  logic [IDX_W-1:0]  dst_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [IDX_W-1:0]  asel_q, bsel_q, csel_q;
  logic [DATA_W-1:0] cin_q;
  logic [DATA_W-1:0] alu_result;

`ifdef REGSEQ_FLAGS_EN
  logic alu_carry;
  logic carry_q;
  logic flag_z_q, flag_c_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    idle_phase  = 1'b0;
    write_phase = 1'b0;
    case (state_q)
      IDLE: begin
        idle_phase = 1'b1;
        if (bus.ins_valid) state_d = READ;
      end
      READ:  state_d = EXEC;
      EXEC:  state_d = WRITE;
      WRITE: begin
        write_phase = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = idle_phase & bus.ins_valid;

  regseq_alu u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .result (alu_result)
`ifdef REGSEQ_FLAGS_EN
    ,
    .carry  (alu_carry)
`endif
  );

  // The ALU result is registered straight into the write-data register so
  // cin is valid for the whole WRITE cycle and holds afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q   <= OP_MOV;
      dst_q  <= '0;
      imm_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      asel_q <= '0;
      bsel_q <= '0;
      csel_q <= '0;
      cin_q  <= '0;
    end else begin
      if (accept) begin
        op_q   <= bus.ins_op;
        dst_q  <= bus.ins_dst;
        imm_q  <= bus.ins_imm;
        asel_q <= bus.ins_srca;
        bsel_q <= bus.ins_srcb;
      end
      if (state_q == READ) begin
        a_q <= bus.aout;
        b_q <= bus.bout;
      end
      if (state_q == EXEC) begin
        csel_q <= dst_q;
        cin_q  <= alu_result;
      end
    end
  end

`ifdef REGSEQ_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      carry_q  <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      if (state_q == EXEC) carry_q <= alu_carry;
      if (state_q == WRITE) begin
        case (op_q)
          OP_ADD, OP_SUB: begin
            flag_z_q <= (cin_q == '0);
            flag_c_q <= carry_q;
          end
          OP_AND, OP_OR, OP_XOR: begin
            flag_z_q <= (cin_q == '0);
            flag_c_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
`endif

  // Gating with rst lets a reset landing in WRITE suppress that edge's write.
  assign bus.ins_ready = idle_phase & rst;
  assign bus.cload     = write_phase & (op_q != OP_NOP) & rst;
  assign done          = write_phase & rst;
  assign bus.asel      = asel_q;
  assign bus.bsel      = bsel_q;
  assign bus.csel      = csel_q;
  assign bus.cin       = cin_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_register_sequencer.sv
// Bench for register_sequencer: register file model, directed cases and
// random instructions against an array-based reference of the register file.
module tb_register_sequencer;
  import regseq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  register_sequencer_if bus();
  state_t dbg_state;
  logic   done;
`ifdef REGSEQ_FLAGS_EN
  logic   flag_z, flag_c;
`endif

  register_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state),
    .done      (done)
`ifdef REGSEQ_FLAGS_EN
    ,
    .flag_z    (flag_z),
    .flag_c    (flag_c)
`endif
  );

  // Register file: combinational reads, write on the rising edge.
  logic [7:0] rf[8];
  assign bus.aout = rf[bus.asel];
  assign bus.bout = rf[bus.bsel];
  always @(posedge clk) if (bus.cload === 1'b1) rf[bus.csel] <= bus.cin;

  logic [7:0]  ref_rf[8];
  bit          ref_z, ref_c;
  logic [11:0] exp_q[$];
  logic [1:0]  fexp_q[$];
  int total = 0, bad = 0;
  int n_done = 0, n_sent = 0;
  bit flag_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // kind: 0 flags untouched, 1 arithmetic (Z and C), 2 logical (Z, C cleared)
  function automatic void model(input logic [2:0] op, input logic [7:0] a, b, imm,
                                output logic [7:0] val, output bit wr,
                                output int kind, output bit c);
    int s;
    wr = 1'b1; c = 1'b0; kind = 0; val = 8'h00;
    case (op)
      3'd0: val = a;
      3'd1: begin s = int'(a) + int'(b); val = 8'(s % 256); c = (s > 255); kind = 1; end
      3'd2: begin s = int'(a) - int'(b); val = 8'((s + 256) % 256); c = (a < b); kind = 1; end
      3'd3: begin val = a & b; kind = 2; end
      3'd4: begin val = a | b; kind = 2; end
      3'd5: begin val = a ^ b; kind = 2; end
      3'd6: val = imm;
      default: wr = 1'b0;
    endcase
  endfunction

  // Scoreboard: each done pulse retires the oldest expected write.
  always @(negedge clk) begin
    logic [11:0] e;
    logic [1:0]  f;
`ifdef REGSEQ_FLAGS_EN
    if (flag_pend) begin
      flag_pend = 1'b0;
      if (fexp_q.size() > 0) begin
        f = fexp_q.pop_front();
        check("flag_z", flag_z, f[1]);
        check("flag_c", flag_c, f[0]);
      end
    end
`endif
    if (done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("cload", bus.cload, e[11]);
        if (e[11]) begin
          check("csel", bus.csel, e[10:8]);
          check("cin", bus.cin, e[7:0]);
        end
`ifdef REGSEQ_FLAGS_EN
        flag_pend = 1'b1;
`endif
      end
    end else if (bus.cload !== 1'b0) begin
      check("cload_without_done", bus.cload, 0);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [2:0] dst, sa, sb,
                      input logic [7:0] imm, input bit hold, input bit commit,
                      output int waited);
    logic [7:0] v;
    bit wr, c;
    int kind;
    bus.ins_op = op; bus.ins_dst = dst; bus.ins_srca = sa; bus.ins_srcb = sb;
    bus.ins_imm = imm; bus.ins_valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.ins_ready !== 1'b1 && waited < 20);
    if (bus.ins_ready !== 1'b1) begin
      check("accept_timeout", 0, 1);
      bus.ins_valid = 1'b0;
      return;
    end
    if (commit) begin
      model(op, ref_rf[sa], ref_rf[sb], imm, v, wr, kind, c);
      exp_q.push_back({wr, dst, v});
      if (wr) ref_rf[dst] = v;
      if (kind == 1) begin ref_z = (v == 8'h00); ref_c = c; end
      else if (kind == 2) begin ref_z = (v == 8'h00); ref_c = 1'b0; end
      fexp_q.push_back({ref_z, ref_c});
      n_sent++;
    end
    @(posedge clk); #1;
    if (!hold) bus.ins_valid = 1'b0;
    bus.ins_op = 3'($urandom_range(0, 7)); bus.ins_dst = 3'($urandom_range(0, 7));
    bus.ins_srca = 3'($urandom_range(0, 7)); bus.ins_srcb = 3'($urandom_range(0, 7));
    bus.ins_imm = 8'($urandom_range(0, 255));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 8; i++) begin rf[i] = 8'h00; ref_rf[i] = 8'h00; end
    ref_z = 1'b0; ref_c = 1'b0;
    bus.ins_valid = 1'b0; bus.ins_op = 3'd0; bus.ins_dst = 3'd0;
    bus.ins_srca = 3'd0; bus.ins_srcb = 3'd0; bus.ins_imm = 8'h00;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.ins_ready, 0);
    check("rst_done", done, 0);
    check("rst_cload", bus.cload, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_csel", bus.csel, 0);
    check("rst_cin", bus.cin, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", bus.ins_ready, 1);
    @(posedge clk); #1;

    // LDI r3 = 0x5A with cycle-exact retire
    send(OP_LDI, 3'd3, 3'd0, 3'd0, 8'h5A, 1'b0, 1'b1, w);
    @(negedge clk);
    check("t1_ready", bus.ins_ready, 0);
    check("t1_done", done, 0);
    @(negedge clk);
    check("t2_done", done, 0);
    @(negedge clk);
    check("t3_done", done, 1);
    check("t3_cload", bus.cload, 1);
    check("t3_csel", bus.csel, 3);
    check("t3_cin", bus.cin, 8'h5A);
    @(negedge clk);
    check("t4_done", done, 0);
    check("t4_ready", bus.ins_ready, 1);
    drain();
    check("r3_ldi", rf[3], 8'h5A);

    // ADD with wrap-around
    send(OP_LDI, 3'd1, 3'd0, 3'd0, 8'hF0, 1'b0, 1'b1, w);
    send(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h20, 1'b0, 1'b1, w);
    send(OP_ADD, 3'd4, 3'd1, 3'd2, 8'h00, 1'b0, 1'b1, w);
    drain();
    check("r4_add_wrap", rf[4], 8'h10);
`ifdef REGSEQ_FLAGS_EN
    check("add_c", flag_c, 1);
    check("add_z", flag_z, 0);
`endif

    // SUB to zero, then SUB with borrow
    send(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h05, 1'b0, 1'b1, w);
    send(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h05, 1'b0, 1'b1, w);
    send(OP_SUB, 3'd1, 3'd1, 3'd1, 8'h00, 1'b0, 1'b1, w);
    drain();
    check("r1_sub_zero", rf[1], 8'h00);
`ifdef REGSEQ_FLAGS_EN
    check("sub_z", flag_z, 1);
    check("sub_c", flag_c, 0);
`endif
    send(OP_SUB, 3'd5, 3'd1, 3'd2, 8'h00, 1'b0, 1'b1, w);
    drain();
    check("r5_sub_borrow", rf[5], 8'hFB);
`ifdef REGSEQ_FLAGS_EN
    check("borrow_c", flag_c, 1);
`endif

    // NOP then MOV with valid held high
    send(OP_NOP, 3'd0, 3'd0, 3'd0, 8'h00, 1'b1, 1'b1, w);
    send(OP_MOV, 3'd7, 3'd4, 3'd4, 8'h00, 1'b0, 1'b1, w);
    check("b2b_gap", w, 4);
    drain();
    check("r7_mov", rf[7], 8'h10);

    // Reset during WRITE of ADD r2 = r2 + r2
    send(OP_ADD, 3'd2, 3'd2, 3'd2, 8'h00, 1'b0, 1'b0, w);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_cload", bus.cload, 0);
    check("abort_done", done, 0);
    check("abort_ready", bus.ins_ready, 0);
    @(posedge clk); #1;
    check("abort_state", dbg_state, IDLE);
    check("abort_asel", bus.asel, 0);
    check("abort_bsel", bus.bsel, 0);
    check("abort_csel", bus.csel, 0);
    check("abort_cin", bus.cin, 0);
    check("abort_r2", rf[2], 8'h05);
    ref_z = 1'b0; ref_c = 1'b0;
`ifdef REGSEQ_FLAGS_EN
    check("abort_flag_z", flag_z, 0);
    check("abort_flag_c", flag_c, 0);
`endif
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_abort", bus.ins_ready, 1);
    @(posedge clk); #1;

    // ins_valid pulsed during READ/EXEC is ignored
    send(OP_MOV, 3'd6, 3'd3, 3'd3, 8'h00, 1'b0, 1'b1, w);
    bus.ins_valid = 1'b1; bus.ins_op = OP_LDI; bus.ins_dst = 3'd0; bus.ins_imm = 8'hEE;
    @(negedge clk);
    check("ignore_ready_read", bus.ins_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ignore_ready_exec", bus.ins_ready, 0);
    @(posedge clk); #1;
    bus.ins_valid = 1'b0;
    drain();
    check("r6_mov", rf[6], 8'h5A);
    check("r0_untouched", rf[0], ref_rf[0]);

    // Random instructions
    for (int n = 0; n < 40; n++) begin
      send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'b1, w);
      bus.ins_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();
    for (int i = 0; i < 8; i++) check($sformatf("rf_final_%0d", i), rf[i], ref_rf[i]);
    check("done_count", n_done, n_sent);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
